pipeline_stall_control: RTL

Pipeline hold/flush sequencer for the 5-stage LC-3b datapath. It consumes `hazard_stall` and `control_flush` from the hazard detector, plus the instruction-memory and data-memory handshakes. From these it produces the per-stage load enables, the ID/EX bubble select and the per-stage flush strobes. It also remembers a redirect that arrives while memory is busy, and keeps saturating performance counters for stall cycles and flush events.

---
 rtl/pipeline_stall_control.sv | 108 ++++++++++
 1 files changed

// File: rtl/pipeline_stall_control.sv
// Hold/flush sequencer for the 5-stage pipeline: load enables, ID/EX bubble, flush strobes, perf counters.
// Latency: enables and strobes are combinational (same cycle); counters and pending redirect update on the next edge.
// Backpressure: any outstanding memory handshake freezes every stage; a redirect seen while frozen is held until release.
module pipeline_stall_control #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hazard_stall,
  input  logic                   control_flush,
  input  logic                   imem_read,
  input  logic                   imem_resp,
  input  logic                   dmem_req,
  input  logic                   dmem_resp,
  output logic                   load_pc,
  output logic                   load_if_id,
  output logic                   load_id_ex,
  output logic                   load_ex_mem,
  output logic                   load_mem_wb,
  output logic                   bubble_id_ex,
  output logic                   flush_if_id,
  output logic                   flush_id_ex,
  output logic                   flush_ex_mem,
  output logic [COUNT_WIDTH-1:0] stall_cycles,
  output logic [COUNT_WIDTH-1:0] flush_events
);

  // HOLD marks that the previous cycle was frozen by memory.
  typedef enum logic {RUN, HOLD} state_t;

  state_t state;
  state_t state_nxt;
  logic   flush_pending;
  logic   pending_nxt;
  logic   mem_wait;
  logic   flush_req;
  logic   stall_inc;
  logic   flush_inc;

  assign mem_wait = (imem_read & ~imem_resp) | (dmem_req & ~dmem_resp);
  // A pending redirect can only exist after a frozen cycle, so it is qualified by HOLD.
  assign flush_req = control_flush | (flush_pending & (state == HOLD));

  // Priority decode: reset, memory freeze, redirect, load-use bubble, normal flow.
  always_comb begin
    load_pc      = 1'b1;
    load_if_id   = 1'b1;
    load_id_ex   = 1'b1;
    load_ex_mem  = 1'b1;
    load_mem_wb  = 1'b1;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    state_nxt    = RUN;
    pending_nxt  = 1'b0;
    if (reset) begin
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      load_id_ex   = 1'b0;
      load_ex_mem  = 1'b0;
      load_mem_wb  = 1'b0;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
    end else if (mem_wait) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
      stall_inc   = 1'b1;
      state_nxt   = HOLD;
      pending_nxt = flush_pending | control_flush;
    end else if (flush_req) begin
      // MEM/WB is left alone so the redirecting instruction retires.
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      flush_inc    = 1'b1;
    end else if (hazard_stall) begin
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      bubble_id_ex = 1'b1;
      stall_inc    = 1'b1;
    end
  end

  // State, pending redirect and saturating counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      flush_pending <= 1'b0;
      stall_cycles  <= '0;
      flush_events  <= '0;
    end else begin
      state         <= state_nxt;
      flush_pending <= pending_nxt;
      if (stall_inc && (stall_cycles != {COUNT_WIDTH{1'b1}}))
        stall_cycles <= stall_cycles + COUNT_WIDTH'(1);
      if (flush_inc && (flush_events != {COUNT_WIDTH{1'b1}}))
        flush_events <= flush_events + COUNT_WIDTH'(1);
    end
  end

endmodule
